// File: rtl/line_drawer_pkg.sv
// rtl/line_drawer_pkg.sv - shared color constants and line rasterizer state type
package line_drawer_pkg;

    localparam int COLOR_WIDTH = 4;

    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'h0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'h1;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'h2;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'h3;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'hf;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } line_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_drawer_if.sv
// rtl/line_drawer_if.sv - line command handshake and pixel write port bundle
interface line_drawer_if #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
);
    import line_drawer_pkg::*;

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                   start;
    logic [XW-1:0]          x0;
    logic [XW-1:0]          x1;
    logic [YW-1:0]          y0;
    logic [YW-1:0]          y1;
    logic [COLOR_WIDTH-1:0] color_in;
    logic                   ready;
    logic                   done;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [COLOR_WIDTH-1:0] color;
    logic                   enable;

    modport master (
        output start, x0, x1, y0, y1, color_in,
        input  ready, done, x, y, color, enable
    );

    modport slave (
        input  start, x0, x1, y0, y1, color_in,
        output ready, done, x, y, color, enable
    );

endinterface

// File: rtl/line_drawer_step.sv
// rtl/line_drawer_step.sv - one combinational Bresenham step (e2 compare and error update)
module line_drawer_step #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int SW = 12
) (
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    input  logic signed [SW-1:0] err,
    input  logic signed [SW-1:0] dx,
    input  logic signed [SW-1:0] dy,
    input  logic signed [1:0]    sx,
    input  logic signed [1:0]    sy,
    output logic [XW-1:0]        x_next,
    output logic [YW-1:0]        y_next,
    output logic signed [SW-1:0] err_next
);

    // e2 needs one bit more than err so doubling never wraps
    logic signed [SW:0] e2;
    logic signed [SW:0] dx_w;
    logic signed [SW:0] dy_w;
    logic               step_x;
    logic               step_y;

    always_comb begin
        e2       = {err, 1'b0};
        dx_w     = {dx[SW-1], dx};
        dy_w     = {dy[SW-1], dy};
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        err_next = err;
        if (step_x) err_next = err_next + dy;
        if (step_y) err_next = err_next + dx;
        x_next   = step_x ? x + XW'(sx) : x;
        y_next   = step_y ? y + YW'(sy) : y;
    end

endmodule

// File: rtl/line_drawer.sv
// rtl/line_drawer.sv - Bresenham line rasterizer, one pixel per clock; LINE_DRAWER_CLIP_EN masks off-canvas pixels
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic         clk,
    input  logic         reset,
    line_drawer_if.slave bus
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SW = imax(XW, YW) + 2;

    line_state_t            state_q, state_n;
    logic [XW-1:0]          x_q, x_n, x1_q, x1_n;
    logic [YW-1:0]          y_q, y_n, y1_q, y1_n;
    logic [COLOR_WIDTH-1:0] color_q, color_n;
    logic                   enable_q, enable_n;
    logic                   done_q, done_n;
    logic signed [SW-1:0]   err_q, err_n, dx_q, dx_n, dy_q, dy_n;
    logic signed [1:0]      sx_q, sx_n, sy_q, sy_n;

    logic signed [SW-1:0]   ddx, ddy, adx, ady;
    logic [XW-1:0]          x_step;
    logic [YW-1:0]          y_step;
    logic signed [SW-1:0]   err_step;
    logic                   start_vis, step_vis;

    line_drawer_step #(.XW(XW), .YW(YW), .SW(SW)) u_step (
        .x        (x_q),
        .y        (y_q),
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx       (sx_q),
        .sy       (sy_q),
        .x_next   (x_step),
        .y_next   (y_step),
        .err_next (err_step)
    );

`ifdef LINE_DRAWER_CLIP_EN
    localparam logic [XW:0] X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0] Y_LIM = (YW+1)'(HEIGHT);
    assign start_vis = ({1'b0, bus.x0} < X_LIM) && ({1'b0, bus.y0} < Y_LIM);
    assign step_vis  = ({1'b0, x_step} < X_LIM) && ({1'b0, y_step} < Y_LIM);
`else
    assign start_vis = 1'b1;
    assign step_vis  = 1'b1;
`endif

    assign ddx = $signed(SW'(bus.x1)) - $signed(SW'(bus.x0));
    assign ddy = $signed(SW'(bus.y1)) - $signed(SW'(bus.y0));
    assign adx = (ddx < 0) ? -ddx : ddx;
    assign ady = (ddy < 0) ? -ddy : ddy;

    always_comb begin
        state_n  = state_q;
        x_n      = x_q;
        y_n      = y_q;
        x1_n     = x1_q;
        y1_n     = y1_q;
        color_n  = color_q;
        err_n    = err_q;
        dx_n     = dx_q;
        dy_n     = dy_q;
        sx_n     = sx_q;
        sy_n     = sy_q;
        enable_n = 1'b0;
        done_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n  = DRAW;
                    x_n      = bus.x0;
                    y_n      = bus.y0;
                    x1_n     = bus.x1;
                    y1_n     = bus.y1;
                    color_n  = bus.color_in;
                    dx_n     = adx;
                    dy_n     = -ady;
                    sx_n     = (bus.x0 < bus.x1) ? 2'sd1 : -2'sd1;
                    sy_n     = (bus.y0 < bus.y1) ? 2'sd1 : -2'sd1;
                    err_n    = adx - ady;
                    enable_n = start_vis;
                end
            end
            DRAW: begin
                if ((x_q == x1_q) && (y_q == y1_q)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    x_n      = x_step;
                    y_n      = y_step;
                    err_n    = err_step;
                    enable_n = step_vis;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= COLOR_NONE;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            x_q      <= x_n;
            y_q      <= y_n;
            x1_q     <= x1_n;
            y1_q     <= y1_n;
            color_q  <= color_n;
            err_q    <= err_n;
            dx_q     <= dx_n;
            dy_q     <= dy_n;
            sx_q     <= sx_n;
            sy_q     <= sy_n;
            enable_q <= enable_n;
            done_q   <= done_n;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.color  = color_q;
    assign bus.enable = enable_q;

endmodule

// File: tb/tb_line_drawer.sv
// tb/tb_line_drawer.sv - directed scoreboard bench for line_drawer; build with LINE_DRAWER_CLIP_EN for the 6x6 clip canvas
module tb_line_drawer;
    import line_drawer_pkg::*;

`ifdef LINE_DRAWER_CLIP_EN
    localparam int W = 6;
    localparam int H = 6;
`else
    localparam int W = 640;
    localparam int H = 480;
`endif
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    typedef struct packed {
        logic [XW-1:0]          x;
        logic [YW-1:0]          y;
        logic [COLOR_WIDTH-1:0] c;
    } px_t;

    logic clk = 1'b0;
    logic reset;

    line_drawer_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    line_drawer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    px_t q[$];
    int  acc_q[$];
    int  done_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  en_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_px(input int x, input int y, input logic [COLOR_WIDTH-1:0] c);
        px_t p;
        if (x < W && y < H) begin
            p.x = XW'(x);
            p.y = YW'(y);
            p.c = c;
            q.push_back(p);
        end
    endtask

    // one clock; pixel strobes are popped against the scoreboard #1 after the edge
    task automatic tick();
        logic acc;
        px_t  e;
        acc = bus.ready && bus.start;
        @(posedge clk);
        cyc++;
        if (acc) acc_q.push_back(cyc);
        #1;
        if (bus.done) begin
            done_cnt++;
            done_q.push_back(cyc);
        end
        if (bus.enable) begin
            en_cnt++;
            if (q.size() == 0) begin
                chk("extra_pixel", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("px_x", 32'(bus.x), 32'(e.x));
                chk("px_y", 32'(bus.y), 32'(e.y));
                chk("px_color", 32'(bus.color), 32'(e.c));
            end
        end
    endtask

    task automatic set_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [COLOR_WIDTH-1:0] c);
        bus.x0 = XW'(x0);
        bus.y0 = YW'(y0);
        bus.x1 = XW'(x1);
        bus.y1 = YW'(y1);
        bus.color_in = c;
    endtask

    task automatic launch(input int x0, input int y0, input int x1, input int y1,
                          input logic [COLOR_WIDTH-1:0] c);
        set_cmd(x0, y0, x1, y1, c);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
        tick();
    endtask

    initial begin
        int e0;
        int d0;
        int first_acc;
        reset = 1'b1;
        bus.start = 1'b0;
        set_cmd(0, 0, 0, 0, COLOR_NONE);
        #3;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_color", 32'(bus.color), 32'(COLOR_NONE));
        tick();
        reset = 1'b0;
        tick();

        // single point
        push_px(3, 5, COLOR_BLUE);
        launch(3, 5, 3, 5, COLOR_BLUE);
        chk("pt_enable", 32'(bus.enable), 32'd1);
        chk("pt_ready_low", 32'(bus.ready), 32'd0);
        tick();
        chk("pt_done", 32'(bus.done), 32'd1);
        chk("pt_enable_off", 32'(bus.enable), 32'd0);
        chk("pt_ready_in_done", 32'(bus.ready), 32'd0);
        tick();
        chk("pt_ready_back", 32'(bus.ready), 32'd1);
        chk("pt_done_off", 32'(bus.done), 32'd0);
        chk("pt_hold_x", 32'(bus.x), 32'd3);
        chk("pt_queue", 32'(q.size()), 32'd0);

        // horizontal
        e0 = en_cnt;
        for (int i = 0; i <= 4; i++) push_px(i, 0, COLOR_RED);
        launch(0, 0, 4, 0, COLOR_RED);
        wait_done("hz_done_timeout");
        chk("hz_count", 32'(en_cnt - e0), 32'd5);
        chk("hz_queue", 32'(q.size()), 32'd0);

        // steep
        e0 = en_cnt;
        push_px(0, 0, COLOR_GREEN);
        push_px(0, 1, COLOR_GREEN);
        push_px(1, 2, COLOR_GREEN);
        push_px(1, 3, COLOR_GREEN);
        push_px(2, 4, COLOR_GREEN);
        push_px(2, 5, COLOR_GREEN);
        launch(0, 0, 2, 5, COLOR_GREEN);
        wait_done("st_done_timeout");
        chk("st_count", 32'(en_cnt - e0), 32'd6);
        chk("st_queue", 32'(q.size()), 32'd0);

        // reverse with start held high, second command queued behind it
        acc_q.delete();
        done_q.delete();
        for (int i = 4; i >= 0; i--) push_px(i, 3, COLOR_RED);
        push_px(1, 1, COLOR_WHITE);
        push_px(2, 2, COLOR_WHITE);
        set_cmd(4, 3, 0, 3, COLOR_RED);
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_q.size() >= 1) set_cmd(1, 1, 2, 2, COLOR_WHITE);
            if (acc_q.size() >= 2) break;
        end
        bus.start = 1'b0;
        wait_done("rv_done_timeout");
        chk("rv_accepts", 32'(acc_q.size()), 32'd2);
        chk("rv_dones", 32'(done_q.size()), 32'd2);
        first_acc = (acc_q.size() > 0) ? acc_q[0] : -100;
        chk("rv_spacing", 32'((acc_q.size() > 1 ? acc_q[1] : 0) - first_acc), 32'd7);
        chk("rv_done_lat", 32'((done_q.size() > 0 ? done_q[0] : 0) - first_acc), 32'd5);
        chk("rv_done2_lat", 32'((done_q.size() > 1 ? done_q[1] : 0) -
                                (acc_q.size() > 1 ? acc_q[1] : 0)), 32'd2);
        chk("rv_queue", 32'(q.size()), 32'd0);

        // reset during pixel 2
        push_px(0, 0, COLOR_BLUE);
        push_px(1, 0, COLOR_BLUE);
        push_px(2, 0, COLOR_BLUE);
        launch(0, 0, 7, 0, COLOR_BLUE);
        tick();
        tick();
        chk("mr_pixel2_x", 32'(bus.x), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mr_enable", 32'(bus.enable), 32'd0);
        chk("mr_ready", 32'(bus.ready), 32'd1);
        chk("mr_x", 32'(bus.x), 32'd0);
        chk("mr_color", 32'(bus.color), 32'(COLOR_NONE));
        d0 = done_cnt;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("mr_no_done", 32'(done_cnt), 32'(d0));
        chk("mr_queue", 32'(q.size()), 32'd0);

        // line crossing the right edge of a 6-wide canvas when clipped
        acc_q.delete();
        done_q.delete();
        e0 = en_cnt;
        for (int i = 3; i <= 7; i++) push_px(i, 0, COLOR_WHITE);
        launch(3, 0, 7, 0, COLOR_WHITE);
        wait_done("cl_done_timeout");
`ifdef LINE_DRAWER_CLIP_EN
        chk("cl_count", 32'(en_cnt - e0), 32'd3);
`else
        chk("cl_count", 32'(en_cnt - e0), 32'd5);
`endif
        chk("cl_done_lat", 32'((done_q.size() > 0 ? done_q[0] : 0) -
                               (acc_q.size() > 0 ? acc_q[0] : -100)), 32'd5);
        chk("cl_queue", 32'(q.size()), 32'd0);
        chk("cl_ready", 32'(bus.ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
# line_drawer

Rasterizes one straight-line command into a stream of single-pixel write strobes using integer Bresenham stepping. Sits directly upstream of `drawing_canvas`; its `x`, `y`, `color`, `enable` outputs connect straight to the canvas write port. It emits one pixel per clock, and a ready/start handshake lets a command source queue lines back-to-back.

## Interface
- `WIDTH`, 640, canvas width in pixels; `XW = $clog2(WIDTH)`
- `HEIGHT`, 480, canvas height in pixels; `YW = $clog2(HEIGHT)`
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `start`  in  1  command valid; sampled only while `ready`=1
- `x0`, `x1`  in  XW  endpoint x coordinates (unsigned)
- `y0`, `y1`  in  YW  endpoint y coordinates (unsigned)
- `color_in`  in  COLOR_WIDTH  line color
- `ready`  out  1  high in IDLE only
- `done`  out  1  one-cycle pulse after the last pixel
- `x`  out  XW  pixel x, registered
- `y`  out  YW  pixel y, registered
- `color`  out  COLOR_WIDTH  pixel color, registered
- `enable`  out  1  pixel write strobe, registered

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: `ready`=1. If `start`=1 at an edge, latch `x0`, `y0`, `x1`, `y1`, `color_in` and go to DRAW.
- Latching on that edge sets the outputs: `x`=x0, `y`=y0, `color`=color_in, `enable`=1.
- Setup values, with signed width `SW = max(XW,YW)+2`:
  - dx = |x1-x0|
  - dy = -|y1-y0|
  - sx = (x0<x1) ? +1 : -1, likewise sy
  - err = dx+dy
- DRAW, each edge:
  - If the current (x,y) equals (x1,y1): `enable`→0, `done`→1, go to DONE.
  - Otherwise compute e2 = 2·err.
  - If e2 ≥ dy: err += dy, x += sx.
  - If e2 ≤ dx: err += dx, y += sy. Both updates use the same e2.
  - `enable` stays 1.
- DONE: `done`=1 for exactly one cycle, then IDLE. `done`→0, `ready`→1.
- Pixel count is max(|dx|,|dy|)+1. A degenerate line (x0=x1, y0=y1) yields exactly one pixel.
- `start` outside IDLE is ignored, including `start` held high through DONE. Command inputs are don't-care except at the accepting edge.
- `x`, `y`, `color` hold their last values when `enable`=0.

## Timing
- Reset values (asynchronous): state=IDLE, `ready`=1, `done`=0, `enable`=0, `x`=0, `y`=0, `color`=COLOR_NONE.
- A command accepted at edge E0 produces `enable`=1 during cycles E0..E(N-1), where N = pixel count.
- `done`=1 during cycle EN. `ready`=1 from E(N+1).
- Minimum command-to-command spacing is N+2 cycles.
- Reset asserted mid-DRAW: outputs drop to reset values immediately. No `done` is produced and the in-flight line is abandoned.

## Configuration
- `LINE_DRAWER_CLIP_EN` defined:
  - `enable` is forced to 0 for any pixel with x ≥ WIDTH or y ≥ HEIGHT.
  - Stepping and cycle count are unchanged, and `done` still fires.
- Not defined: `enable` is asserted for every stepped pixel regardless of bounds.

## Structure
- COLOR_WIDTH and the COLOR_* constants come from the shared common package.
- Add the state enum `line_state_t` (IDLE, DRAW, DONE) to that package.
- One combinational sub-module, `line_drawer_step`: takes x, y, err, dx, dy, sx, sy and returns next x, y, err. It keeps the e2 comparisons and signed-width handling isolated and testable.

## Test plan
- Single point (3,5)→(3,5), color BLUE: one `enable` cycle at (3,5), `done` the next cycle, `ready` the cycle after.
- Horizontal (0,0)→(4,0): five consecutive `enable` cycles with x=0,1,2,3,4 and y=0, then `done`.
- Steep (0,0)→(2,5): pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5) in order, then `done`.
- Reverse (4,3)→(0,3) with `start` held high throughout:
  - x=4,3,2,1,0.
  - The held `start` is ignored until `ready`.
  - A second line starts exactly N+2 cycles after the first acceptance.
- Reset mid-line during pixel 2 of (0,0)→(7,0): `enable`=0 and `ready`=1 immediately; no `done` pulse.
- With `LINE_DRAWER_CLIP_EN`, WIDTH=6, HEIGHT=6, line (3,0)→(7,0):
  - Five stepping cycles.
  - `enable`=1 only for x=3,4,5.
  - `done` on the sixth cycle.
